muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS-PUM core. It accepts the 5-bit ALU operation code from the ALU control module together with both operands, and runs MULT/MULTU/DIV/DIVU as a 32-iteration shift-add / restoring-divide sequence. It exposes a busy flag so the pipeline hazard logic stalls MFHI/MFLO and any new mul/div while an operation is in flight. MTHI/MTLO are handled as single-cycle register writes.

## Interface
- WIDTH, 32: operand, HI and LO width; the iteration count equals WIDTH.
- iCLK  in  1  system clock; all state changes on the rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iStart  in  1  request qualifier; iControlSignal/iA/iB are sampled when iStart=1.
- iControlSignal  in  5  ALU op code (OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO); any other code is ignored.
- iA  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- iB  in  WIDTH  rt operand: multiplier or divisor.
- oBusy  out  1  operation in progress; the pipeline stalls MFHI/MFLO/mul/div while it is 1.
- oDone  out  1  one-cycle pulse when new HI/LO values become visible.
- oDivByZero  out  1  one-cycle pulse, coincident with oDone, on DIV/DIVU with iB=0.
- oHI  out  WIDTH  HI register.
- oLO  out  WIDTH  LO register.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - CALC: 32 iterations, counter 31 down to 0.
  - FIX: signed result correction.
  - DONE: result committed, oDone asserted.
- Accepting a request (only in IDLE or DONE; ignored in CALC/FIX):
  - OPMTHI/OPMTLO: write iA into HI/LO at that edge. State goes to or stays IDLE. No oDone, no busy.
  - Mul/div: latch |iA| and |iB| (magnitudes only for signed ops), plus the result-sign and remainder-sign flags, then go to CALC.
  - DIV/DIVU with iB=0: go directly to DONE with LO=all ones, HI=iA, and oDivByZero=1.
- CALC, multiply: 64-bit {HI_acc,LO_acc} shift-add over 32 iterations, unsigned.
- CALC, divide: restoring division over 32 iterations, unsigned. Quotient goes to LO_acc, remainder to HI_acc.
- FIX:
  - Signed multiply: negate the 64-bit product when the operand signs differ.
  - Signed divide: the quotient sign is sign(A) xor sign(B); the remainder sign follows the dividend.
  - Unsigned ops pass through unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- DONE: commit the accumulators to oHI/oLO. oDone=1. Next state is IDLE, or CALC if a new mul/div is accepted in the same cycle.
- Reset, at any time including mid-CALC: state=IDLE, counter=0, oHI=oLO=0, oBusy=oDone=oDivByZero=0. Any in-flight operation is discarded.

## Timing
- A request accepted at edge 0 gives:
  - oBusy=1 during cycles 1–33 (32 CALC cycles + 1 FIX cycle).
  - oDone=1 in cycle 34.
  - oHI/oLO valid from cycle 34 onward.
- Divide-by-zero: oDone and oDivByZero in cycle 1; oBusy never asserts.
- MTHI/MTLO: oHI/oLO updated in cycle 1.
- oBusy is a registered decode of the state (CALC or FIX), with no combinational path from iStart.
- Back-to-back: a request accepted in the DONE cycle starts CALC at the next edge. The committed HI/LO remain readable during that cycle.
- MTHI/MTLO arriving while busy is ignored. Hazard logic never issues it then, so it is not counted as an error.

## Structure
- Op codes (OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO) come from the shared ALU-op parameter package; this block defines no new codes.
- The FSM state encoding is local to the block.
- One natural sub-module: muldiv_core_step, a combinational single-iteration step (shift-add or trial-subtract) selected by a mode bit. The FSM and registers stay in muldiv_sequencer.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; oDone exactly in cycle 34; oBusy high cycles 1–33.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 ÷ 7 → LO=14, HI=2.
- DIVU 100 ÷ 0 → oDivByZero and oDone in cycle 1, LO=0xFFFFFFFF, HI=100, oBusy never 1.
- Assert iRST at cycle 10 of a MULT → oBusy=0 and oHI=oLO=0 immediately. A following MULTU 3×5 then gives LO=15 at cycle 34.
- MTHI 0x12345678 in IDLE → oHI=0x12345678 next cycle. A second MULT pulsed during CALC is ignored, and the first result is unchanged.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU-op codes seen by the multiply/divide sequencer, plus small
// decode helpers so the top-level accept logic reads cleanly.
package muldiv_sequencer_pkg;

  localparam logic [4:0] OPMTHI  = 5'd17;
  localparam logic [4:0] OPMTLO  = 5'd19;
  localparam logic [4:0] OPMULT  = 5'd24;
  localparam logic [4:0] OPMULTU = 5'd25;
  localparam logic [4:0] OPDIV   = 5'd26;
  localparam logic [4:0] OPDIVU  = 5'd27;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == OPMULT) || (op == OPMULTU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == OPMULT) || (op == OPDIV);
  endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// One iteration of the multiply/divide datapath. Multiply mode does a
// conditional add of the multiplicand into HI and shifts {carry,HI,LO} right.
// Divide mode shifts {HI,LO} left and keeps the trial subtraction if it
// does not borrow, feeding the quotient bit into LO[0].
module muldiv_core_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Both candidate results are formed; the mode bit picks one.
  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    rem_sh = {hi_i, lo_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    if (div_mode) begin
      // diff[WIDTH] is the borrow: set means the divisor did not fit.
      if (!diff[WIDTH]) begin
        hi_o = diff[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = rem_sh[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair. Operands are
// reduced to magnitudes on accept, iterated unsigned for WIDTH cycles, then
// sign-corrected in a single FIX cycle and committed to HI/LO.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [4:0]       iControlSignal,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivByZero,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0] step_hi, step_lo;
  logic             accept, sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_neg;

  muldiv_core_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (div_q),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Next-state, accept decode and sign correction.
  always_comb begin
    accept    = iStart && (state_q == ST_IDLE || state_q == ST_DONE);
    sgn       = is_signed_op(iControlSignal);
    a_mag     = (sgn && iA[WIDTH-1]) ? -iA : iA;
    b_mag     = (sgn && iB[WIDTH-1]) ? -iB : iB;
    prod_neg  = -{acc_hi_q, acc_lo_q};

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      ST_CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (!div_q && neg_res_q) begin
          {hi_d, lo_d} = prod_neg;
        end else begin
          hi_d = (div_q && neg_rem_q) ? -acc_hi_q : acc_hi_q;
          lo_d = (div_q && neg_res_q) ? -acc_lo_q : acc_lo_q;
        end
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    if (accept) begin
      if (iControlSignal == OPMTHI) begin
        hi_d    = iA;
        state_d = ST_IDLE;
      end else if (iControlSignal == OPMTLO) begin
        lo_d    = iA;
        state_d = ST_IDLE;
      end else if (is_mul_op(iControlSignal)) begin
        state_d   = ST_CALC;
        cnt_d     = CW'(WIDTH - 1);
        acc_hi_d  = '0;
        acc_lo_d  = b_mag;
        opnd_d    = a_mag;
        div_d     = 1'b0;
        neg_res_d = sgn && (iA[WIDTH-1] ^ iB[WIDTH-1]);
        neg_rem_d = 1'b0;
      end else if (is_div_op(iControlSignal)) begin
        if (iB == '0) begin
          // Divide by zero short-circuits straight to a committed result.
          state_d = ST_DONE;
          hi_d    = iA;
          lo_d    = '1;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
        end else begin
          state_d   = ST_CALC;
          cnt_d     = CW'(WIDTH - 1);
          acc_hi_d  = '0;
          acc_lo_d  = a_mag;
          opnd_d    = b_mag;
          div_d     = 1'b1;
          neg_res_d = sgn && (iA[WIDTH-1] ^ iB[WIDTH-1]);
          neg_rem_d = sgn && iA[WIDTH-1];
        end
      end
    end

    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
  end

  // FSM and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oDivByZero = dbz_q;
  assign oHI        = hi_q;
  assign oLO        = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected HI/LO and
// completion cycle from an arithmetic reference; a monitor pops on oDone.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W = 32;

  logic         iCLK = 1'b0;
  logic         iRST;
  logic         iStart;
  logic [4:0]   iControlSignal;
  logic [W-1:0] iA, iB;
  logic         oBusy, oDone, oDivByZero;
  logic [W-1:0] oHI, oLO;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .iStart         (iStart),
    .iControlSignal (iControlSignal),
    .iA             (iA),
    .iB             (iB),
    .oBusy          (oBusy),
    .oDone          (oDone),
    .oDivByZero     (oDivByZero),
    .oHI            (oHI),
    .oLO            (oLO)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit products and SV integer division semantics.
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    logic [63:0] p;
    longint      sa, sb2;
    int          ia, ib;
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    if (op == OPMULTU) begin
      p = {32'd0, a} * {32'd0, b};
      hi = p[63:32]; lo = p[31:0];
    end else if (op == OPMULT) begin
      sa = longint'($signed(a));
      sb2 = longint'($signed(b));
      p = sa * sb2;
      hi = p[63:32]; lo = p[31:0];
    end else if (b == 0) begin
      dbz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
    end else if (op == OPDIVU) begin
      lo = a / b; hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000; hi = 0;
    end else begin
      ia = $signed(a); ib = $signed(b);
      lo = ia / ib; hi = ia % ib;
    end
  endfunction

  // Drive a request for one edge; optionally record its expected result.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    iControlSignal = op; iA = a; iB = b; iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    if (push) begin
      model(op, a, b, e.hi, e.lo, e.dbz);
      e.due = cyc + (e.dbz ? 0 : 33);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 80; k++) begin
      @(negedge iCLK); #2;
      if (sb.size() == 0 && !oBusy) break;
    end
    if (sb.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every oDone must match the oldest outstanding request.
  always @(negedge iCLK) begin
    if (!iRST) begin
      if (oDone) begin
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_done: hi %h lo %h at cycle %0d", oHI, oLO, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("hi", oHI, e.hi);
          check("lo", oLO, e.lo);
          check("divbyzero", oDivByZero, e.dbz);
          check("done_cycle", cyc, e.due);
        end
      end else if (oDivByZero) begin
        n_chk++; n_err++;
        $display("FAIL dbz_without_done: got 1 expected 0 at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [4:0] ops [4];

  initial begin
    ops[0] = OPMULT; ops[1] = OPMULTU; ops[2] = OPDIV; ops[3] = OPDIVU;
    iRST = 1'b1; iStart = 1'b0; iControlSignal = '0; iA = '0; iB = '0;
    repeat (2) @(posedge iCLK); #1;
    check("reset_hi", oHI, 0);
    check("reset_lo", oLO, 0);
    check("reset_ctl", {oBusy, oDone, oDivByZero}, 0);
    @(negedge iCLK); iRST = 1'b0;
    @(negedge iCLK);

    // MULTU max x max with cycle-accurate busy profile
    issue(OPMULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    for (int n = 1; n <= 34; n++) begin
      @(negedge iCLK);
      check($sformatf("busy_c%0d", n), oBusy, (n <= 33) ? 1 : 0);
    end
    drain();

    issue(OPMULT, 32'hFFFF_FFFD, 32'd7, 1);          drain();
    issue(OPDIV,  32'hFFFF_FFF9, 32'd2, 1);          drain();
    issue(OPDIVU, 32'd100, 32'd7, 1);                drain();
    issue(OPDIV,  32'h8000_0000, 32'hFFFF_FFFF, 1);  drain();
    issue(OPDIV,  32'd7, 32'hFFFF_FFFE, 1);          drain();

    // Divide by zero completes at once, never busy
    issue(OPDIVU, 32'd100, 32'd0, 1);
    @(negedge iCLK);
    check("dbz_busy", oBusy, 0);
    drain();

    // MTHI/MTLO land in cycle 1 with no completion pulse
    issue(OPMTHI, 32'h1234_5678, 32'd0, 0);
    check("mthi", oHI, 32'h1234_5678);
    issue(OPMTLO, 32'hCAFE_BABE, 32'd0, 0);
    check("mtlo", oLO, 32'hCAFE_BABE);
    check("mt_busy", oBusy, 0);

    // Unknown op code does nothing
    issue(5'd0, 32'd5, 32'd5, 0);
    @(negedge iCLK);
    check("badop_busy", oBusy, 0);
    check("badop_hi", oHI, 32'h1234_5678);

    // Second MULT during CALC is ignored
    issue(OPMULT, 32'd6, 32'hFFFF_FFFE, 1);
    repeat (5) @(negedge iCLK);
    issue(OPMULT, 32'd99, 32'd99, 0);
    issue(OPMTHI, 32'hDEAD_BEEF, 32'd0, 0);
    drain();
    repeat (40) @(negedge iCLK);
    check("ignored_hi", oHI, 32'hFFFF_FFFF);
    check("ignored_lo", oLO, 32'hFFFF_FFF4);

    // Reset at cycle 10 of a MULT discards it
    issue(OPMULT, 32'd12345, 32'hFFFF_FFF7, 0);
    repeat (9) @(negedge iCLK);
    iRST = 1'b1; #1;
    check("rst_busy", oBusy, 0);
    check("rst_hi", oHI, 0);
    check("rst_lo", oLO, 0);
    @(negedge iCLK); iRST = 1'b0;
    @(negedge iCLK);
    issue(OPMULTU, 32'd3, 32'd5, 1);
    drain();
    check("post_rst_lo", oLO, 15);

    // Randomized ops; drain returns in the DONE cycle so many are back-to-back
    for (int t = 0; t < 40; t++) begin
      logic [4:0]   op;
      logic [W-1:0] a, b;
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: a = a >> $urandom_range(0, 31);
        2: b = b >> $urandom_range(0, 31);
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      issue(op, a, b, 1);
      drain();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge iCLK);
    end

    repeat (5) @(negedge iCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
